// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 32-bit ISA words and streams
// them into instruction memory at incrementing addresses. It is used as the
// program loader / self-test generator before the CPU leaves reset.
// Optional build macro: ENC_ILLEGAL_TRAP_EN. When it is defined, illegal
// opcodes are written as a nop and a sticky err_illegal flag is raised.
// When it is undefined, illegal opcodes are packed in the R-type layout
// and err_illegal is tied low.
module instr_encoder #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [4:0]        alu_op,
    input  logic [16:0]       imm,
    input  logic [26:0]       target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              imem_wren,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       word;
    logic              last_q;
    logic [31:0]       packed_word;
`ifdef ENC_ILLEGAL_TRAP_EN
    logic              illegal;
    logic              err_q;
`endif

    // Pack the presented fields into an ISA word according to the opcode's format.
    always_comb begin
        packed_word = {opcode, rd, rs, rt, shamt, alu_op, 2'b00};
`ifdef ENC_ILLEGAL_TRAP_EN
        illegal     = 1'b0;
`endif
        case (opcode)
            5'b00000: packed_word = {opcode, rd, rs, rt, shamt, alu_op, 2'b00};
            5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110:
                packed_word = {opcode, rd, rs, imm};
            5'b00001, 5'b00011, 5'b10101, 5'b10110:
                packed_word = {opcode, target};
            5'b00100: packed_word = {opcode, rd, 22'd0};
            default: begin
`ifdef ENC_ILLEGAL_TRAP_EN
                packed_word = 32'h0000_0000;
                illegal     = 1'b1;
`else
                packed_word = {opcode, rd, rs, rt, shamt, alu_op, 2'b00};
`endif
            end
        endcase
    end

    // Session state machine: capture a tuple in LOAD, strobe it out for one WRITE cycle, stop at last/DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            word_count <= '0;
            word       <= '0;
            last_q     <= 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        addr       <= '0;
                        word_count <= '0;
`ifdef ENC_ILLEGAL_TRAP_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        word   <= packed_word;
                        last_q <= in_last;
`ifdef ENC_ILLEGAL_TRAP_EN
                        if (illegal) begin
                            err_q <= 1'b1;
                        end
`endif
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    word_count <= word_count + 1'b1;
                    if (addr != LAST_ADDR) begin
                        addr <= addr + 1'b1;
                    end
                    if (last_q || addr == LAST_ADDR) begin
                        state <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe is masked by reset so a strobe caught by reset is never emitted.
    assign imem_wren = (state == WRITE) && !reset;
    assign in_ready  = (state == LOAD);
    assign busy      = (state == LOAD) || (state == WRITE);
    assign done      = (state == DONE);
    assign imem_addr = addr;
    assign imem_data = word;
    assign count     = word_count;
`ifdef ENC_ILLEGAL_TRAP_EN
    assign err_illegal = err_q;
`else
    assign err_illegal = 1'b0;
`endif

endmodule
